// File: rtl/chess_pkg.sv
// chess_pkg: shared types for the chessboard move-entry block.
//   coord_t      - 3-bit board coordinate, row 0 is the top rank
//   square_t     - {row, col} pair
//   move_state_t - selection FSM states IDLE / SRC / REQ
//   step_coord   - one wrap-around cursor step on an axis of BOARD_N squares
package chess_pkg;

   localparam int BOARD_N = 8;

   typedef logic [2:0] coord_t;

   typedef struct packed {
      coord_t row;
      coord_t col;
   } square_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SRC  = 2'd1,
      REQ  = 2'd2
   } move_state_t;

   // Opposing presses in the same cycle cancel, so the coordinate holds.
   function automatic coord_t step_coord(input coord_t c, input logic inc, input logic dec);
      coord_t r;
      r = c;
      if (inc && !dec) begin
         r = (c == coord_t'(BOARD_N - 1)) ? '0 : c + coord_t'(1);
      end else if (dec && !inc) begin
         r = (c == '0) ? coord_t'(BOARD_N - 1) : c - coord_t'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   2-flop synchronizer -> stability counter -> stable level -> 1-cycle press pulse.
//   Optional auto-repeat when built with MOVE_ENTRY_AUTOREPEAT_EN and REPEAT_ALLOWED=1.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   btn_raw_i in   raw asynchronous button, active-high
//   press_o   out  registered press pulse (one cycle per accepted press / repeat)
module btn_debounce
   import chess_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 12500000,
   parameter bit REPEAT_ALLOWED  = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw_i,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             stable_prev_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rpt_hit;

   // The counter only advances while the synchronized level disagrees with the
   // accepted level; any agreeing cycle restarts the qualification window.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef MOVE_ENTRY_AUTOREPEAT_EN
   localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

   // Counting starts the cycle after the initial press pulse is generated, so
   // repeats land exactly REPEAT_CYCLES apart from the first pulse.
   always_comb begin
      rpt_cnt_d = '0;
      rpt_hit   = 1'b0;
      if (REPEAT_ALLOWED && stable_q && stable_prev_q) begin
         if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
            rpt_hit   = 1'b1;
            rpt_cnt_d = '0;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_cnt_q <= '0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
      end
   end
`else
   logic unused_rpt;
   assign unused_rpt = ^{REPEAT_CYCLES, REPEAT_ALLOWED};
   assign rpt_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
         press_q       <= 1'b0;
      end else begin
         sync1_q       <= btn_raw_i;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         cnt_q         <= cnt_d;
         // Rising edge of the accepted level only; releases are silent.
         press_q       <= (stable_q & ~stable_prev_q) | rpt_hit;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/move_entry_ctrl.sv
// move_entry_ctrl: player input sequencer for the 8x8 chessboard display.
//   Debounces five buttons, moves a wrap-around cursor, runs the IDLE/SRC/REQ
//   selection FSM and issues a move request to game logic.
//   Optional auto-repeat of direction buttons: define MOVE_ENTRY_AUTOREPEAT_EN.
// Handshake: move_valid is raised on entry to REQ and the move fields are frozen
//   while it is high; the request completes on the edge where move_valid and
//   move_ready are both 1, and move_valid is low the following cycle. Only reset
//   withdraws a pending request.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   btn_up/down/left/right/sel            raw buttons, active-high
//   frame_start                           1-cycle pulse at start of vertical blanking
//   move_valid / move_ready               request handshake
//   move_src_row/col, move_dst_row/col    requested squares
//   disp_cur_row/col                      cursor for display (frame-synchronous)
//   disp_sel_active, disp_sel_row/col     held source for display (frame-synchronous)
//   dbg_state_o, dbg_cursor_o             live FSM state and cursor
module move_entry_ctrl
   import chess_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   input  logic        frame_start,
   output logic        move_valid,
   input  logic        move_ready,
   output logic [2:0]  move_src_row,
   output logic [2:0]  move_src_col,
   output logic [2:0]  move_dst_row,
   output logic [2:0]  move_dst_col,
   output logic [2:0]  disp_cur_row,
   output logic [2:0]  disp_cur_col,
   output logic        disp_sel_active,
   output logic [2:0]  disp_sel_row,
   output logic [2:0]  disp_sel_col,
   output move_state_t dbg_state_o,
   output square_t     dbg_cursor_o
);

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_SEL   = 4;

   logic [4:0]  raw;
   logic [4:0]  press;
   move_state_t state_q, state_d;
   square_t     cur_q, cur_d;
   square_t     src_q, src_d;
   square_t     dst_q, dst_d;
   logic        valid_q, valid_d;
   square_t     disp_cur_q, disp_sel_q;
   logic        disp_act_q;

   assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

   for (genvar g = 0; g < 5; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .REPEAT_ALLOWED  (g != BTN_SEL)
      ) u_db (
         .clk       (clk),
         .reset_n   (reset_n),
         .btn_raw_i (raw[g]),
         .press_o   (press[g])
      );
   end

   // Cursor moves in every state, rows and columns independently.
   always_comb begin
      cur_d     = cur_q;
      cur_d.row = step_coord(cur_q.row, press[BTN_DOWN], press[BTN_UP]);
      cur_d.col = step_coord(cur_q.col, press[BTN_RIGHT], press[BTN_LEFT]);
   end

   // Selections latch cur_q, i.e. the pre-move cursor when a direction press
   // coincides with sel.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      case (state_q)
         IDLE: begin
            if (press[BTN_SEL]) begin
               src_d   = cur_q;
               state_d = SRC;
            end
         end
         SRC: begin
            if (press[BTN_SEL]) begin
               if (cur_q == src_q) begin
                  state_d = IDLE;
               end else begin
                  dst_d   = cur_q;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (valid_q && move_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         valid_q <= valid_d;
      end
   end

   // Shadow copies sample the registered (pre-change) values so highlights
   // only change between frames.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp_cur_q <= '0;
         disp_sel_q <= '0;
         disp_act_q <= 1'b0;
      end else if (frame_start) begin
         disp_cur_q <= cur_q;
         disp_sel_q <= src_q;
         disp_act_q <= (state_q != IDLE);
      end
   end

   assign move_valid      = valid_q;
   assign move_src_row    = src_q.row;
   assign move_src_col    = src_q.col;
   assign move_dst_row    = dst_q.row;
   assign move_dst_col    = dst_q.col;
   assign disp_cur_row    = disp_cur_q.row;
   assign disp_cur_col    = disp_cur_q.col;
   assign disp_sel_active = disp_act_q;
   assign disp_sel_row    = disp_sel_q.row;
   assign disp_sel_col    = disp_sel_q.col;
   assign dbg_state_o     = state_q;
   assign dbg_cursor_o    = cur_q;

endmodule

// File: tb/tb_move_entry_ctrl.sv
// Directed bench for move_entry_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_move_entry_ctrl;
   import chess_pkg::*;

   localparam logic [4:0] B_UP    = 5'b00001;
   localparam logic [4:0] B_DOWN  = 5'b00010;
   localparam logic [4:0] B_LEFT  = 5'b00100;
   localparam logic [4:0] B_RIGHT = 5'b01000;
   localparam logic [4:0] B_SEL   = 5'b10000;

   logic        clk;
   logic        reset_n;
   logic [4:0]  btn;
   logic        frame_start;
   logic        move_ready;
   logic        move_valid;
   logic [2:0]  move_src_row, move_src_col, move_dst_row, move_dst_col;
   logic [2:0]  disp_cur_row, disp_cur_col;
   logic        disp_sel_active;
   logic [2:0]  disp_sel_row, disp_sel_col;
   move_state_t dbg_state;
   square_t     dbg_cursor;

   int n_checks = 0;
   int n_err    = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   move_entry_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_CYCLES   (10)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .btn_up          (btn[0]),
      .btn_down        (btn[1]),
      .btn_left        (btn[2]),
      .btn_right       (btn[3]),
      .btn_sel         (btn[4]),
      .frame_start     (frame_start),
      .move_valid      (move_valid),
      .move_ready      (move_ready),
      .move_src_row    (move_src_row),
      .move_src_col    (move_src_col),
      .move_dst_row    (move_dst_row),
      .move_dst_col    (move_dst_col),
      .disp_cur_row    (disp_cur_row),
      .disp_cur_col    (disp_cur_col),
      .disp_sel_active (disp_sel_active),
      .disp_sel_row    (disp_sel_row),
      .disp_sel_col    (disp_sel_col),
      .dbg_state_o     (dbg_state),
      .dbg_cursor_o    (dbg_cursor)
   );

   // ---------------- driver tasks ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold for 8 cycles (press accepted, cursor updated), then release long
   // enough for the stable level to return to 0.
   task automatic press(input logic [4:0] mask);
      btn = mask;
      repeat (8) @(negedge clk);
      btn = '0;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [31:0] cur6();
      return 32'({dbg_cursor.row, dbg_cursor.col});
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      reset_n     = 1'b0;
      btn         = '0;
      frame_start = 1'b0;
      move_ready  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_valid",  32'(move_valid), 0);
      chk("rst_state",  32'(dbg_state), 0);
      chk("rst_cursor", cur6(), 0);
      chk("rst_outs",   32'({move_src_row, move_src_col, move_dst_row, move_dst_col,
                             disp_cur_row, disp_cur_col, disp_sel_active,
                             disp_sel_row, disp_sel_col}), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: glitches never qualify
      btn = B_DOWN; @(negedge clk);
      btn = '0;     @(negedge clk);
      btn = B_DOWN; @(negedge clk);
      btn = '0;     @(negedge clk);
      btn = B_DOWN; @(negedge clk);
      btn = '0;
      repeat (10) @(negedge clk);
      chk("glitch_cursor", cur6(), 0);

      // held: first sampled at edge k, cursor changes at edge k+7
      btn = B_DOWN;
      repeat (7) @(negedge clk);
      chk("latency_before", cur6(), 0);
      @(negedge clk);
      chk("latency_at", cur6(), 6'o10);
      repeat (12) @(negedge clk);
      btn = '0;
      repeat (10) @(negedge clk);
`ifdef MOVE_ENTRY_AUTOREPEAT_EN
      chk("held_20", cur6(), 6'o20);
`else
      chk("held_20", cur6(), 6'o10);
`endif

      do_reset();
      chk("rebase_cursor", cur6(), 0);

      // 2: column wrap, row wrap, opposing presses
      for (int i = 1; i <= 8; i++) begin
         press(B_RIGHT);
         chk("right_step", 32'(dbg_cursor.col), i % 8);
      end
      press(B_UP);
      chk("up_wrap", cur6(), 6'o70);
      press(B_UP | B_DOWN);
      chk("up_down_cancel", cur6(), 6'o70);
      press(B_LEFT | B_RIGHT);
      chk("left_right_cancel", cur6(), 6'o70);

      // 3: full request with back-pressure
      press(B_UP);
      repeat (4) press(B_RIGHT);
      chk("at_64", cur6(), 6'o64);
      press(B_SEL);
      chk("src_state", 32'(dbg_state), 1);
      chk("src_no_valid", 32'(move_valid), 0);
      press(B_UP);
      press(B_UP);
      press(B_SEL);
      chk("req_state", 32'(dbg_state), 2);
      chk("req_valid", 32'(move_valid), 1);
      chk("req_fields", 32'({move_src_row, move_src_col, move_dst_row, move_dst_col}), 12'o6444);
      press(B_SEL);
      press(B_LEFT);
      chk("hold_valid", 32'(move_valid), 1);
      chk("hold_fields", 32'({move_src_row, move_src_col, move_dst_row, move_dst_col}), 12'o6444);
      chk("hold_state", 32'(dbg_state), 2);
      chk("hold_cursor", cur6(), 6'o43);
      move_ready = 1'b1;
      @(negedge clk);
      move_ready = 1'b0;
      chk("hs_valid_low", 32'(move_valid), 0);
      chk("hs_state_idle", 32'(dbg_state), 0);

      // 4: select then cancel on the same square; ready outside REQ is inert
      press(B_UP);
      press(B_UP);
      move_ready = 1'b1;
      press(B_SEL);
      chk("sel23_state", 32'(dbg_state), 1);
      frame_pulse();
      chk("sel23_disp_act", 32'(disp_sel_active), 1);
      chk("sel23_disp_sq", 32'({disp_sel_row, disp_sel_col}), 6'o23);
      chk("sel23_disp_cur", 32'({disp_cur_row, disp_cur_col}), 6'o23);
      press(B_SEL);
      move_ready = 1'b0;
      chk("cancel_state", 32'(dbg_state), 0);
      chk("cancel_valid", 32'(move_valid), 0);
      chk("cancel_disp_hold", 32'(disp_sel_active), 1);
      frame_pulse();
      chk("cancel_disp_act", 32'(disp_sel_active), 0);

      // 5: display shadow only loads on frame_start, with pre-change value
      press(B_RIGHT);
      chk("shadow_hold", 32'({disp_cur_row, disp_cur_col}), 6'o23);
      frame_pulse();
      chk("shadow_load", 32'({disp_cur_row, disp_cur_col}), 6'o24);
      btn = B_RIGHT;
      repeat (7) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("shadow_same_cycle", 32'({disp_cur_row, disp_cur_col}), 6'o24);
      chk("cursor_same_cycle", cur6(), 6'o25);
      btn = '0;
      repeat (8) @(negedge clk);
      frame_pulse();
      chk("shadow_after", 32'({disp_cur_row, disp_cur_col}), 6'o25);

      // 6: reset while a request is pending
      press(B_SEL);
      press(B_RIGHT);
      press(B_SEL);
      chk("req2_valid", 32'(move_valid), 1);
      chk("req2_fields", 32'({move_src_row, move_src_col, move_dst_row, move_dst_col}), 12'o2526);
      frame_pulse();
      chk("req2_disp_act", 32'(disp_sel_active), 1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_outs", 32'({move_valid, move_src_row, move_src_col, move_dst_row,
                                 move_dst_col, disp_cur_row, disp_cur_col, disp_sel_active,
                                 disp_sel_row, disp_sel_col}), 0);
      chk("async_rst_state", 32'(dbg_state), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // long hold on left: pulses at acceptance+1, +10, +20, +30 when repeating
      btn = B_LEFT;
      repeat (40) @(negedge clk);
      btn = '0;
      repeat (20) @(negedge clk);
`ifdef MOVE_ENTRY_AUTOREPEAT_EN
      chk("left_hold_col", 32'(dbg_cursor.col), 4);
`else
      chk("left_hold_col", 32'(dbg_cursor.col), 7);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/move_entry_ctrl.md
Name: move_entry_ctrl

Overview:
- Sequences player input for the on-screen 8x8 chessboard.
- Debounces five push-buttons, moves a cursor over the board, and runs a source/destination selection FSM.
- Issues a valid/ready move request to game logic.
- Presents cursor and selection coordinates to the pixel generator, updated only at frame start so highlights never tear mid-frame.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles needed to accept a button level change (10 ms at 50 MHz).
- REPEAT_CYCLES, 12500000, auto-repeat interval for held direction buttons; only used with AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  raw asynchronous buttons, active-high
- frame_start  in  1  one-cycle pulse in clk domain at first line of vertical blanking
- move_valid  out  1  move request pending
- move_ready  in  1  game logic accepts request
- move_src_row, move_src_col, move_dst_row, move_dst_col  out  3 each  requested move squares, row 0 = top
- disp_cur_row, disp_cur_col  out  3 each  cursor square for display
- disp_sel_active  out  1  a source square is held (state != IDLE)
- disp_sel_row, disp_sel_col  out  3 each  held source square for display

Behaviour:
- Reset (async assert on reset_n low, release synchronous to clk): all outputs 0, state IDLE, cursor (0,0), debounce counters 0, stable levels 0.
- Per button:
  - 2-flop synchronizer.
  - Counter counts while sync output differs from the stable level; it clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, the stable level flips and the counter clears.
  - A registered press pulse (1 cycle) fires on each 0->1 flip of the stable level. Releases produce no pulse.
- Latency: raw high first sampled at edge k, held steady -> press pulse high during cycle after edge k+2+DEBOUNCE_CYCLES; cursor register updates at the next edge.
- Cursor movement, wrap-around mod 8:
  - Up: row-1, row 0 -> 7.
  - Down: row+1, row 7 -> 0.
  - Left: col-1, col 0 -> 7.
  - Right: col+1, col 7 -> 0.
  - Row and column are updated independently in the same cycle.
  - up+down in the same cycle: no row change. left+right in the same cycle: no col change.
  - Cursor moves in every state.
- FSM states IDLE, SRC, REQ:
  - IDLE: sel press -> src <= cursor, go SRC.
  - SRC, sel press with cursor == src: cancel, go IDLE.
  - SRC, sel press with cursor != src: dst <= cursor, go REQ. A direction press in the same cycle as sel uses the pre-move cursor.
  - REQ: move_valid = 1; move_src_* and move_dst_* held stable. sel presses ignored.
  - REQ, move_valid && move_ready at an edge: go IDLE; move_valid low the next cycle.
  - move_ready while not in REQ has no effect.
- move_valid is registered, high exactly in REQ. It never drops without a handshake except on reset.
- Display shadow registers load live {cursor, state!=IDLE, src} on cycles where frame_start = 1; otherwise they hold. A change and frame_start in the same cycle: the shadow takes the pre-change value.
- Reset mid-request: move_valid drops asynchronously; the request is discarded.

Optional Feature:
- Macro: MOVE_ENTRY_AUTOREPEAT_EN.
- Defined:
  - While a direction button's stable level stays 1, a per-button repeat counter generates an additional press pulse every REPEAT_CYCLES cycles after the initial press.
  - The counter clears on release.
  - sel never repeats.
- Undefined: exactly one pulse per press; repeat counters and REPEAT_CYCLES logic are absent.

Decomposition:
- Package chess_pkg:
  - typedef logic [2:0] coord_t.
  - packed struct square_t {coord_t row; coord_t col;}.
  - enum logic [1:0] move_state_t {IDLE, SRC, REQ}.
  - localparam BOARD_N = 8.
- Sub-module btn_debounce (synchronizer, counter, stable level, press pulse, optional repeat), instantiated 5 times.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
1. Reset, then btn_down high for 3 cycles with 1-cycle glitches -> no pulse, cursor stays (0,0). Held 20 cycles -> cursor (1,0) exactly DEBOUNCE_CYCLES+3 edges after first sample; one step only.
2. 8 clean btn_right presses -> col goes 1..7 then wraps to 0. btn_up from row 0 -> row 7. up+down together -> row unchanged.
3. sel at (6,4), move to (4,4), sel -> move_valid=1 with src (6,4), dst (4,4). Hold move_ready=0 for 5 cycles with extra sel/moves -> fields stable. move_ready=1 -> handshake, move_valid=0 next cycle, state IDLE.
4. sel at (2,3), then sel again at (2,3) -> back to IDLE, no move_valid, disp_sel_active returns 0 after next frame_start.
5. Move cursor with frame_start low -> disp_cur_* unchanged. Pulse frame_start -> disp_cur_* updates. Change and frame_start in the same cycle -> old value shown.
6. Assert reset_n low while move_valid=1 -> all outputs 0 immediately. With MOVE_ENTRY_AUTOREPEAT_EN, hold btn_left 35 cycles past acceptance -> 4 col decrements.
